// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready stream bundle for fifo_rd_stream_adapter.
// m_parity exists only when FIFO_RD_ADAPT_PARITY_EN is defined.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 5
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
`ifdef FIFO_RD_ADAPT_PARITY_EN
    logic                  m_parity;

    modport master (
        input  fifo_empty, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, m_parity
    );
    modport slave (
        output fifo_empty, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, m_parity
    );
`else
    modport master (
        input  fifo_empty, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );
    modport slave (
        output fifo_empty, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
`endif
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a registered-read FIFO into a framed valid/ready stream through a 2-entry buffer.
// Optional even parity output enabled by defining FIFO_RD_ADAPT_PARITY_EN.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 5,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_stream_adapter_if.master bus,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam int BEAT_W = $clog2(PKT_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ;
    occ_t                  occ_nxt;
    logic                  inflight;
    logic                  cap;
    logic                  pop;
    logic                  valid;
    logic [2:0]            fill_after_pop;
    logic [DATA_WIDTH-1:0] head_p2;
    logic [DATA_WIDTH-1:0] tail_p2;
    logic [BEAT_W-1:0]     beat_cnt;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    assign cap = inflight;

    // Stage p0: read issue; a read is in flight for exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= EMPTY;
        end else begin
            occ <= occ_nxt;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case (occ)
            EMPTY: if (cap) occ_nxt = ONE;
            ONE: begin
                if (cap && !pop) begin
                    occ_nxt = TWO;
                end else if (!cap && pop) begin
                    occ_nxt = EMPTY;
                end
            end
            TWO: if (!cap && pop) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    // Issue only when the word would still fit after this cycle's capture and pop
    always_comb begin
        valid          = (occ != EMPTY);
        pop            = valid & bus.m_ready;
        fill_after_pop = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        bus.fifo_rd_en = ~bus.fifo_empty & ~rst & (fill_after_pop < 3'd2);
        bus.m_valid    = valid;
    end

    // Stage p1 -> p2: the word returned by the FIFO lands in head or tail
    always_ff @(posedge clk) begin
        if (cap) begin
            if (occ == EMPTY || (occ == ONE && pop)) begin
                head_p2 <= bus.fifo_data_out;
            end else if (occ == ONE) begin
                tail_p2 <= bus.fifo_data_out;
            end else begin
                head_p2 <= tail_p2;
                tail_p2 <= bus.fifo_data_out;
            end
        end else if (pop && occ == TWO) begin
            head_p2 <= tail_p2;
        end
    end

    assign bus.m_data = valid ? head_p2 : '0;
    assign bus.m_last = valid & (beat_cnt == LAST_BEAT);

`ifdef FIFO_RD_ADAPT_PARITY_EN
    logic head_par_p2;
    logic tail_par_p2;

    always_ff @(posedge clk) begin
        if (cap) begin
            if (occ == EMPTY || (occ == ONE && pop)) begin
                head_par_p2 <= even_parity(bus.fifo_data_out);
            end else if (occ == ONE) begin
                tail_par_p2 <= even_parity(bus.fifo_data_out);
            end else begin
                head_par_p2 <= tail_par_p2;
                tail_par_p2 <= even_parity(bus.fifo_data_out);
            end
        end else if (pop && occ == TWO) begin
            head_par_p2 <= tail_par_p2;
        end
    end

    assign bus.m_parity = valid & head_par_p2;
`endif

    // Framing: beat counter advances only on accepted beats and holds across gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            pkt_count <= '0;
        end else if (pop) begin
            if (bus.m_last) begin
                beat_cnt  <= '0;
                pkt_count <= pkt_count + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: queue-based FIFO and stream reference model.
module tb_fifo_rd_stream_adapter;
    localparam int DW  = 5;
    localparam int PL  = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] pkt_count;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            infl_m = 0;
    int            beat_m = 0;
    logic [CW-1:0] cnt_m  = '0;

    logic          s_rd, s_valid, s_last, s_par;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;

    int cyc = 0;
    int n_pops = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;
    int first_last_beat = 0;
    int n_push = 0;

    typedef struct {
        bit            ready;
        bit            rd;
        bit            valid;
        logic [DW-1:0] data;
        bit            last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        n_push++;
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: sample and check at negedge, then advance the models just after posedge.
    task automatic cycle();
        bit            v_e, pop_e, rd_e;
        logic [DW-1:0] w;
        @(negedge clk);
        s_rd    = bus.fifo_rd_en;
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_last  = bus.m_last;
        s_cnt   = pkt_count;
`ifdef FIFO_RD_ADAPT_PARITY_EN
        s_par   = bus.m_parity;
`else
        s_par   = 1'b0;
`endif
        v_e   = (exp_q.size() - infl_m) != 0;
        pop_e = v_e && bus.m_ready;
        rd_e  = (fifo_q.size() != 0) && !rst && ((exp_q.size() - int'(pop_e)) < 2);
        chk("m_valid", s_valid, v_e);
        chk("fifo_rd_en", s_rd, rd_e);
        chk("m_last", s_last, v_e && (beat_m == PL - 1));
        chk("pkt_count", s_cnt, cnt_m);
        if (v_e) begin
            chk("m_data", s_data, exp_q[0]);
`ifdef FIFO_RD_ADAPT_PARITY_EN
            chk("m_parity", s_par, ^exp_q[0]);
`endif
        end
        if (s_rd && fifo_q.size() == 0) chk("rd_while_empty", 1, 0);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            infl_m = 0;
            beat_m = 0;
            cnt_m  = '0;
        end else begin
            if (pop_e) begin
                void'(exp_q.pop_front());
                if (n_pops == 0) first_pop_cyc = cyc;
                n_pops++;
                last_pop_cyc = cyc;
                if (s_last && first_last_beat == 0) first_last_beat = n_pops;
                if (beat_m == PL - 1) begin
                    beat_m = 0;
                    cnt_m  = cnt_m + 1'b1;
                end else begin
                    beat_m++;
                end
            end
            infl_m = (s_rd && fifo_q.size() != 0) ? 1 : 0;
            if (infl_m == 1) begin
                w = fifo_q.pop_front();
                bus.fifo_data_out = w;
                exp_q.push_back(w);
            end
            chk("occupancy_le_2", exp_q.size() <= 2, 1);
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   rd_cnt;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 5'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 5'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 5'h01, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 5'h02, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'h03, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 5'h00, 1'b0};

        rst               = 1'b1;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = '0;
        bus.m_ready       = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        chk("reset_rd_en", s_rd, 0);
        chk("reset_m_valid", s_valid, 0);
        chk("reset_m_data", s_data, 0);
        chk("reset_m_last", s_last, 0);
        chk("reset_pkt_count", s_cnt, 0);

        // Three words, first read right after reset, two-cycle latency
        rst = 1'b0;
        push_word(5'h01); push_word(5'h02); push_word(5'h03);
        for (int i = 0; i < 6; i++) begin
            bus.m_ready = tbl[i].ready;
            cycle();
            chk("t1_rd_en", s_rd, tbl[i].rd);
            chk("t1_m_valid", s_valid, tbl[i].valid);
            if (tbl[i].valid) chk("t1_m_data", s_data, tbl[i].data);
            chk("t1_m_last", s_last, tbl[i].last);
        end

        // Eight back-to-back beats, two packets
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_pops = 0;
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        bus.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        chk("t2_beats", n_pops, 8);
        chk("t2_no_bubble", last_pop_cyc - first_pop_cyc, 7);
        chk("t2_pkt_count", pkt_count, 2);

        // Back-pressure: only two reads while stalled, head holds
        n_pops = 0;
        rd_cnt = 0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'(i));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_rd) rd_cnt++;
        end
        chk("t3_reads_stalled", rd_cnt, 2);
        chk("t3_head_valid", s_valid, 1);
        chk("t3_head_data", s_data, 0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        chk("t3_all_out", n_pops, 6);

        // Toggling ready with a full FIFO, then random traffic
        n_pops = 0;
        n_push = 0;
        push_word(5'b10110);
        push_word(5'b00011);
        for (int i = 0; i < 40; i++) begin
            while (fifo_q.size() < 8) push_word(DW'($urandom_range(0, 31)));
            bus.m_ready = (i % 2 == 0);
            cycle();
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push_word(DW'($urandom_range(0, 31)));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) cycle();
        chk("t4_drained", exp_q.size() + fifo_q.size(), 0);
        chk("t4_no_loss", n_pops, n_push);

        // Reset while a word is buffered and another is in flight
        bus.m_ready = 1'b0;
        push_word(5'h11); push_word(5'h12); push_word(5'h13); push_word(5'h14);
        cycle();
        cycle();
        chk("t5_pre_buffered", exp_q.size(), 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t5_rst_rd_en", s_rd, 0);
        chk("t5_rst_m_valid", s_valid, 0);
        chk("t5_rst_m_data", s_data, 0);
        chk("t5_rst_m_last", s_last, 0);
        chk("t5_rst_pkt_count", s_cnt, 0);
        n_pops = 0;
        first_last_beat = 0;
        for (int i = 0; i < 8; i++) push_word(DW'(5'h18 + i));
        bus.m_ready = 1'b1;
        for (int i = 0; i < 14; i++) cycle();
        chk("t5_first_last_beat", first_last_beat, 4);
        chk("t5_beats", n_pops, 8);
        chk("t5_pkt_count", pkt_count, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
